// File: rtl/multififo_push_arbiter.sv
// multififo_push_arbiter: shares the multififo push side among REQ_NUM producers.
// Each producer offers an atomic bundle. At most one bundle is granted per cycle,
// in round-robin order, and only when it fits in the leading free push slots.
// After a flush, grants stay blocked for FLUSH_HOLD cycles.
// Optional build macro MULTIFIFO_PUSH_ARBITER_PERF_EN adds perf_stall_cnt, a
// saturating count of cycles where requests were pending but nothing was granted.
module multififo_push_arbiter #(
  parameter int unsigned REQ_NUM    = 3,
  parameter int unsigned PORT_NUM   = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FLUSH_HOLD = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [REQ_NUM-1:0]                req_valid,
  input  logic [REQ_NUM*PORT_NUM*WIDTH-1:0] req_data,
  input  logic [REQ_NUM*PORT_NUM-1:0]       req_data_valid,
  output logic [REQ_NUM-1:0]                req_ack,
  input  logic [PORT_NUM-1:0]               fifo_data_in_enable,
  input  logic                              fifo_full,
  output logic [PORT_NUM*WIDTH-1:0]         fifo_data_in,
  output logic [PORT_NUM-1:0]               fifo_data_in_valid,
  output logic                              fifo_push
`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(PORT_NUM) + 1;
  localparam int unsigned PW = $clog2(REQ_NUM);
  localparam int unsigned HW = $clog2(FLUSH_HOLD + 1);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [CW-1:0]      free_cnt;
  logic [CW-1:0]      n_req [REQ_NUM];
  logic [REQ_NUM-1:0] elig;
  logic               arb_open;
  logic               grant;
  logic [PW-1:0]      gnt_idx;
  logic [CW-1:0]      n_gnt;
  int unsigned        scan_idx;

  // Free push slots: length of the leading run of ones in the enable mask.
  always_comb begin
    logic run;
    run      = 1'b1;
    free_cnt = '0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      run = run & fifo_data_in_enable[k];
      if (run) free_cnt = free_cnt + CW'(1);
    end
  end

  // Bundle size per producer: leading run of valid entries, later bits ignored.
  always_comb begin
    logic run;
    run = 1'b1;
    for (int unsigned r = 0; r < REQ_NUM; r++) begin
      n_req[r] = '0;
      run      = 1'b1;
      for (int unsigned k = 0; k < PORT_NUM; k++) begin
        run = run & req_data_valid[r*PORT_NUM + k];
        if (run) n_req[r] = n_req[r] + CW'(1);
      end
    end
  end

  assign arb_open = !rst && !flush && (state_q == ST_RUN);

  // Eligibility: empty bundles are always acceptable (dropped without a push).
  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < REQ_NUM; r++) begin
      elig[r] = arb_open && req_valid[r] &&
                ((n_req[r] == '0) || (!fifo_full && (n_req[r] <= free_cnt)));
    end
  end

  // Round-robin pick: first eligible producer starting from rr_ptr.
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int unsigned off = 0; off < REQ_NUM; off++) begin
      scan_idx = (32'(rr_ptr_q) + off) % REQ_NUM;
      if (!grant && elig[scan_idx]) begin
        grant   = 1'b1;
        gnt_idx = PW'(scan_idx);
      end
    end
  end

  assign n_gnt = n_req[gnt_idx];

  // Drive ack and the multififo push side from the granted bundle.
  always_comb begin
    req_ack            = '0;
    fifo_push          = 1'b0;
    fifo_data_in_valid = '0;
    fifo_data_in       = '0;
    if (grant) begin
      req_ack[gnt_idx] = 1'b1;
      fifo_push        = (n_gnt != '0);
      for (int unsigned k = 0; k < PORT_NUM; k++) begin
        if (CW'(k) < n_gnt) begin
          fifo_data_in_valid[k]          = 1'b1;
          fifo_data_in[k*WIDTH +: WIDTH] = req_data[(32'(gnt_idx)*PORT_NUM + k)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next state: flush (re)arms the hold window; RUN advances the pointer on grant.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      state_d    = ST_HOLD;
      hold_cnt_d = HW'(FLUSH_HOLD);
      rr_ptr_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (grant) rr_ptr_d = (gnt_idx == PW'(REQ_NUM - 1)) ? '0 : gnt_idx + PW'(1);
        end
        ST_HOLD: begin
          hold_cnt_d = hold_cnt_q - HW'(1);
          if (hold_cnt_q <= HW'(1)) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // State registers; reset overrides flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of RUN cycles with pending requests but no grant.
  always_comb begin
    perf_d = perf_q;
    if (!flush && (state_q == ST_RUN) && (|req_valid) && !grant && (perf_q != '1))
      perf_d = perf_q + 32'd1;
  end

  // Counter register; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_multififo_push_arbiter.sv
module tb_multififo_push_arbiter;

  localparam int REQ = 3;
  localparam int PN  = 4;
  localparam int W   = 32;
  localparam int FH  = 2;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [REQ-1:0]          req_valid;
  logic [REQ*PN*W-1:0]     req_data;
  logic [REQ*PN-1:0]       req_data_valid;
  logic [REQ-1:0]          req_ack;
  logic [PN-1:0]           fifo_data_in_enable;
  logic                    fifo_full;
  logic [PN*W-1:0]         fifo_data_in;
  logic [PN-1:0]           fifo_data_in_valid;
  logic                    fifo_push;
`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
  logic [31:0]             perf_stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  // Reference state: next producer to favour, remaining blocked cycles, stall count.
  int          m_rr      = 0;
  int          m_blocked = 0;
  logic [31:0] m_perf    = 0;

  multififo_push_arbiter #(
    .REQ_NUM(REQ), .PORT_NUM(PN), .WIDTH(W), .FLUSH_HOLD(FH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_data_valid(req_data_valid),
    .req_ack(req_ack),
    .fifo_data_in_enable(fifo_data_in_enable), .fifo_full(fifo_full),
    .fifo_data_in(fifo_data_in), .fifo_data_in_valid(fifo_data_in_valid),
    .fifo_push(fifo_push)
`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lead_ones(input logic [PN-1:0] v);
    int c = 0;
    while (c < PN && v[c]) c++;
    return c;
  endfunction

  task automatic set_bundle(input int r, input bit v, input logic [PN-1:0] m);
    req_valid[r]               = v;
    req_data_valid[r*PN +: PN] = m;
    for (int k = 0; k < PN; k++) req_data[(r*PN + k)*W +: W] = $urandom;
  endtask

  // One clock: check outputs mid-cycle against the reference, optionally against
  // directed constants, then advance the reference across the clock edge.
  task automatic cycle(input string tag, input bit chk,
                       input logic [REQ-1:0] w_ack, input logic [PN-1:0] w_val);
    int n [REQ];
    int free, g, r;
    logic [REQ-1:0]  e_ack;
    logic            e_push;
    logic [PN-1:0]   e_val;
    logic [PN*W-1:0] e_data;
    #4;
    free = lead_ones(fifo_data_in_enable);
    for (int i = 0; i < REQ; i++) n[i] = lead_ones(req_data_valid[i*PN +: PN]);
    g = -1;
    if (!rst && !flush && m_blocked == 0) begin
      for (int i = 0; i < REQ; i++) begin
        r = (m_rr + i) % REQ;
        if (g < 0 && req_valid[r] && (n[r] == 0 || (!fifo_full && n[r] <= free))) g = r;
      end
    end
    e_ack  = '0;
    e_push = 1'b0;
    e_val  = '0;
    e_data = '0;
    if (g >= 0) begin
      e_ack[g] = 1'b1;
      e_push   = (n[g] > 0);
      for (int k = 0; k < n[g]; k++) begin
        e_val[k]            = 1'b1;
        e_data[k*W +: W]    = req_data[(g*PN + k)*W +: W];
      end
    end

    tests++;
    assert (req_ack === e_ack) else begin
      failed++; $error("FAIL %s ack: got %b expected %b", tag, req_ack, e_ack);
    end
    tests++;
    assert (fifo_push === e_push) else begin
      failed++; $error("FAIL %s push: got %b expected %b", tag, fifo_push, e_push);
    end
    tests++;
    assert (fifo_data_in_valid === e_val) else begin
      failed++; $error("FAIL %s valid: got %b expected %b", tag, fifo_data_in_valid, e_val);
    end
    tests++;
    assert (fifo_data_in === e_data) else begin
      failed++; $error("FAIL %s data: got %h expected %h", tag, fifo_data_in, e_data);
    end
    if (chk) begin
      tests++;
      assert (req_ack === w_ack) else begin
        failed++; $error("FAIL %s dir_ack: got %b expected %b", tag, req_ack, w_ack);
      end
      tests++;
      assert (fifo_data_in_valid === w_val) else begin
        failed++; $error("FAIL %s dir_valid: got %b expected %b", tag, fifo_data_in_valid, w_val);
      end
    end
`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
    tests++;
    assert (perf_stall_cnt === m_perf) else begin
      failed++; $error("FAIL %s perf: got %0d expected %0d", tag, perf_stall_cnt, m_perf);
    end
`endif

    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_blocked = 0; m_perf = '0;
    end else begin
      if (!flush && m_blocked == 0 && (|req_valid) && g < 0 && m_perf != 32'hFFFF_FFFF)
        m_perf = m_perf + 32'd1;
      if (flush) begin
        m_blocked = FH; m_rr = 0;
      end else begin
        if (m_blocked > 0) m_blocked--;
        if (g >= 0) m_rr = (g + 1) % REQ;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0; req_data_valid = '0;
    fifo_data_in_enable = '1; fifo_full = 1'b0;
    @(posedge clk); #1;

    // Reset holds everything quiet even with live requests.
    for (int r = 0; r < REQ; r++) set_bundle(r, 1'b1, 4'b0001);
    cycle("reset0", 1'b1, 3'b000, 4'b0000);
    cycle("reset1", 1'b1, 3'b000, 4'b0000);
    rst = 1'b0;

    // Round robin over three single-entry bundles.
    cycle("rr0", 1'b1, 3'b001, 4'b0001);
    cycle("rr1", 1'b1, 3'b010, 4'b0001);
    cycle("rr2", 1'b1, 3'b100, 4'b0001);

    // Big bundle does not fit; the small one goes first, then the big one.
    set_bundle(0, 1'b1, 4'b0111);
    set_bundle(1, 1'b1, 4'b0001);
    set_bundle(2, 1'b0, 4'b0000);
    fifo_data_in_enable = 4'b0011;
    cycle("fit_small", 1'b1, 3'b010, 4'b0001);
    set_bundle(1, 1'b0, 4'b0000);
    fifo_data_in_enable = 4'b1111;
    cycle("fit_big", 1'b1, 3'b001, 4'b0111);

    // Entries after the first invalid one are ignored.
    set_bundle(0, 1'b1, 4'b1011);
    cycle("lead_run", 1'b1, 3'b001, 4'b0011);

    // Flush blocks grants in T, T+1, T+2; T+3 restarts at producer 0.
    for (int r = 0; r < REQ; r++) set_bundle(r, 1'b1, 4'b0001);
    flush = 1'b1;
    cycle("flush_t0", 1'b1, 3'b000, 4'b0000);
    flush = 1'b0;
    cycle("flush_t1", 1'b1, 3'b000, 4'b0000);
    cycle("flush_t2", 1'b1, 3'b000, 4'b0000);
    cycle("flush_t3", 1'b1, 3'b001, 4'b0001);

    // Full FIFO: only an empty bundle is acked, with no push.
    set_bundle(0, 1'b1, 4'b0001);
    set_bundle(1, 1'b0, 4'b0000);
    set_bundle(2, 1'b1, 4'b0000);
    fifo_full = 1'b1; fifo_data_in_enable = 4'b0000;
    cycle("full_empty", 1'b1, 3'b100, 4'b0000);
    set_bundle(2, 1'b0, 4'b0000);
    cycle("full_block", 1'b1, 3'b000, 4'b0000);
    fifo_full = 1'b0; fifo_data_in_enable = 4'b1111;

    // Reset during the hold window returns straight to RUN.
    flush = 1'b1;
    cycle("hold_flush", 1'b1, 3'b000, 4'b0000);
    flush = 1'b0; rst = 1'b1;
    cycle("hold_rst", 1'b1, 3'b000, 4'b0000);
    rst = 1'b0;
    cycle("hold_exit", 1'b1, 3'b001, 4'b0001);

    // Five blocked cycles with no free slot.
    rst = 1'b1;
    cycle("perf_rst", 1'b1, 3'b000, 4'b0000);
    rst = 1'b0;
    set_bundle(0, 1'b1, 4'b0001);
    fifo_data_in_enable = 4'b0000;
    for (int i = 0; i < 5; i++) cycle("stall", 1'b1, 3'b000, 4'b0000);
`ifdef MULTIFIFO_PUSH_ARBITER_PERF_EN
    tests++;
    assert (perf_stall_cnt === 32'd5) else begin
      failed++; $error("FAIL perf5: got %0d expected 5", perf_stall_cnt);
    end
    rst = 1'b1;
    cycle("perf_clr", 1'b1, 3'b000, 4'b0000);
    rst = 1'b0;
    tests++;
    assert (perf_stall_cnt === 32'd0) else begin
      failed++; $error("FAIL perf0: got %0d expected 0", perf_stall_cnt);
    end
`endif
    fifo_data_in_enable = 4'b1111;

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < REQ; r++) set_bundle(r, 1'($urandom_range(0, 1)), 4'($urandom));
      fifo_data_in_enable = 4'($urandom);
      fifo_full           = ($urandom_range(0, 3) == 0);
      cycle("rand", 1'b0, 3'b000, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
